// File: rtl/perf_event_counter_bank.sv
// Bank of per-event performance counters with atomic snapshot-and-clear over valid/ready.
// Optional sticky overflow flags are built when PERF_COUNTER_OVERFLOW_FLAGS_EN is defined.

module perf_event_counter_lane #(
  parameter int COUNTER_WIDTH = 7,
  parameter int INC_WIDTH     = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cnt_en,
  input  logic [INC_WIDTH-1:0]     inc_raw,
  input  logic                     sat_mode,
  input  logic                     accept,
  output logic [COUNTER_WIDTH-1:0] cnt_q,
  output logic [COUNTER_WIDTH-1:0] snap_q
`ifdef PERF_COUNTER_OVERFLOW_FLAGS_EN
  , output logic                   ovf_q,
  output logic                     snap_ovf_q
`endif
);
  localparam int W = COUNTER_WIDTH;

  logic [W-1:0] inc;
  logic [W:0]   sum;
  logic [W-1:0] nxt;
  logic [W-1:0] cnt_d;
  logic [W-1:0] snap_d;

  always_comb begin
    inc    = cnt_en ? W'(inc_raw) : '0;
    sum    = {1'b0, cnt_q} + {1'b0, inc};
    nxt    = (sat_mode && sum[W]) ? {W{1'b1}} : sum[W-1:0];
    // On accept the pre-increment count leaves with the snapshot and this cycle's
    // increment opens the new interval, so nothing is lost or counted twice.
    cnt_d  = accept ? inc : nxt;
    snap_d = accept ? cnt_q : snap_q;
  end

`ifdef PERF_COUNTER_OVERFLOW_FLAGS_EN
  logic ovf_d;
  logic snap_ovf_d;
  always_comb begin
    ovf_d      = sum[W] | (ovf_q & ~accept);
    snap_ovf_d = accept ? ovf_q : snap_ovf_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      snap_q     <= '0;
`ifdef PERF_COUNTER_OVERFLOW_FLAGS_EN
      ovf_q      <= 1'b0;
      snap_ovf_q <= 1'b0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
`ifdef PERF_COUNTER_OVERFLOW_FLAGS_EN
      ovf_q      <= ovf_d;
      snap_ovf_q <= snap_ovf_d;
`endif
    end
  end
endmodule

module perf_event_counter_bank #(
  parameter int N_EVENTS      = 115,
  parameter int COUNTER_WIDTH = 7,
  parameter int INC_WIDTH     = 1,
  parameter int SEQ_WIDTH     = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic [N_EVENTS-1:0]               event_mask,
  input  logic [N_EVENTS*INC_WIDTH-1:0]     events,
  input  logic                              sat_mode,
  input  logic                              snap_req,
  input  logic                              snap_ready,
  output logic                              snap_valid,
  output logic [N_EVENTS*COUNTER_WIDTH-1:0] snap_counters,
  output logic [SEQ_WIDTH-1:0]              snap_seq,
  output logic                              snap_dropped,
  output logic [N_EVENTS*COUNTER_WIDTH-1:0] live_counters
`ifdef PERF_COUNTER_OVERFLOW_FLAGS_EN
  , output logic [N_EVENTS-1:0]             overflow,
  output logic [N_EVENTS-1:0]               snap_overflow
`endif
);
  localparam int N = N_EVENTS;
  localparam int W = COUNTER_WIDTH;

  logic [N-1:0][W-1:0]         cnt;
  logic [N-1:0][W-1:0]         snap;
  logic [N-1:0][INC_WIDTH-1:0] ev;

  logic                 accept;
  logic                 snap_valid_q, snap_valid_d;
  logic [SEQ_WIDTH-1:0] snap_seq_q, snap_seq_d;
  logic                 snap_dropped_q, snap_dropped_d;

  assign ev = events;

  always_comb begin
    accept         = snap_req & (~snap_valid_q | snap_ready);
    snap_dropped_d = snap_req & ~accept;
    snap_seq_d     = accept ? snap_seq_q + 1'b1 : snap_seq_q;
    snap_valid_d   = snap_valid_q;
    if (accept)          snap_valid_d = 1'b1;
    else if (snap_ready) snap_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_valid_q   <= 1'b0;
      snap_seq_q     <= '0;
      snap_dropped_q <= 1'b0;
    end else begin
      snap_valid_q   <= snap_valid_d;
      snap_seq_q     <= snap_seq_d;
      snap_dropped_q <= snap_dropped_d;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    perf_event_counter_lane #(
      .COUNTER_WIDTH(W),
      .INC_WIDTH    (INC_WIDTH)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .cnt_en    (en & event_mask[i]),
      .inc_raw   (ev[i]),
      .sat_mode  (sat_mode),
      .accept    (accept),
      .cnt_q     (cnt[i]),
      .snap_q    (snap[i])
`ifdef PERF_COUNTER_OVERFLOW_FLAGS_EN
      , .ovf_q   (overflow[i]),
      .snap_ovf_q(snap_overflow[i])
`endif
    );
  end

  assign live_counters = cnt;
  assign snap_counters = snap;
  assign snap_valid    = snap_valid_q;
  assign snap_seq      = snap_seq_q;
  assign snap_dropped  = snap_dropped_q;
endmodule
